// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction prefetch buffer between fetch and decode. Holds
//                up to DEPTH {instruction, PC+4} pairs in a circular array,
//                presents the oldest pair to decode through a valid/ready
//                handshake, stalls the PC when full, is emptied by a taken
//                branch, and shows an all-zero NOP bubble while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         Instr_in,
    input  logic [WIDTH-1:0]         PC_plus4_in,
    input  logic                     Fetch_Valid,
    input  logic                     Flush,
    input  logic                     Dec_Ready,
    output logic                     PC_EN,
    output logic                     Dec_Valid,
    output logic [WIDTH-1:0]         Instr_out,
    output logic [WIDTH-1:0]         PC_plus4_out,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

    // Storage array; contents after reset are don't-care, so it has no reset.
    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic mem_we;

    // Status flags come only from the registered occupancy, never from inputs.
    always_comb begin
        full  = (count_q == C_FULL_CNT);
        empty = (count_q == '0);
        push  = Fetch_Valid && !full;
        pop   = !empty && Dec_Ready;
    end

    // Next-state for pointers and occupancy: flush beats push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_we   = 1'b0;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + C_CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - C_CNT_ONE;
            end
        end
    end

    // Pointer and occupancy registers; reset empties the queue at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write at the write pointer when a push is accepted.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            instr_mem_q[wr_ptr_q] <= Instr_in;
            pc_mem_q[wr_ptr_q]    <= PC_plus4_in;
        end
    end

    // Head presentation; an empty queue shows zeros so decode sees a NOP.
    always_comb begin
        PC_EN        = !full;
        Dec_Valid    = !empty;
        Count        = count_q;
        Instr_out    = '0;
        PC_plus4_out = '0;
        if (!empty) begin
            Instr_out    = instr_mem_q[rd_ptr_q];
            PC_plus4_out = pc_mem_q[rd_ptr_q];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Scoreboard bench for fetch_queue. The driver keeps an ordered
//                list of pairs the queue should hold; a separate monitor
//                compares the DUT head/status against it and retires entries
//                on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [WIDTH-1:0] Instr_in = '0;
    logic [WIDTH-1:0] PC_plus4_in = '0;
    logic             Fetch_Valid = 1'b0;
    logic             Flush = 1'b0;
    logic             Dec_Ready = 1'b0;
    logic             PC_EN;
    logic             Dec_Valid;
    logic [WIDTH-1:0] Instr_out;
    logic [WIDTH-1:0] PC_plus4_out;
    logic [$clog2(DEPTH):0] Count;

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Instr_in     (Instr_in),
        .PC_plus4_in  (PC_plus4_in),
        .Fetch_Valid  (Fetch_Valid),
        .Flush        (Flush),
        .Dec_Ready    (Dec_Ready),
        .PC_EN        (PC_EN),
        .Dec_Valid    (Dec_Valid),
        .Instr_out    (Instr_out),
        .PC_plus4_out (PC_plus4_out),
        .Count        (Count)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Expected queue contents: {instr, pc_plus4}, oldest first.
    logic [2*WIDTH-1:0] exp_q [$];

    // Inputs driven in the cycle now ending, applied to the model after the edge.
    logic             fv_prev = 1'b0;
    logic             fl_prev = 1'b0;
    logic             full_prev = 1'b0;
    logic [WIDTH-1:0] ins_prev = '0;
    logic [WIDTH-1:0] pc_prev = '0;

    int               seen_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares at the falling edge and retires the head on handshake.
    always @(negedge CLK) begin
        if (RST) begin
            chk("count", 64'(Count), 64'(exp_q.size()));
            chk("dec_valid", 64'(Dec_Valid), 64'(exp_q.size() != 0));
            chk("pc_en", 64'(PC_EN), 64'(exp_q.size() != DEPTH));
            if (Instr_out == 32'hDEADBEEF) seen_bad++;
            if (exp_q.size() == 0) begin
                chk("instr_bubble", 64'(Instr_out), 64'h0);
                chk("pc_bubble", 64'(PC_plus4_out), 64'h0);
            end else begin
                chk("instr_head", 64'(Instr_out), 64'(exp_q[0][2*WIDTH-1:WIDTH]));
                chk("pc_head", 64'(PC_plus4_out), 64'(exp_q[0][WIDTH-1:0]));
                if (Dec_Ready && !Flush) void'(exp_q.pop_front());
            end
        end
    end

    // One clock cycle: account for last cycle's push/flush, then drive new inputs.
    task automatic step(input logic fv, input logic [WIDTH-1:0] ins,
                        input logic [WIDTH-1:0] pc, input logic fl, input logic rdy);
        @(posedge CLK);
        #1;
        if (fl_prev) exp_q.delete();
        else if (fv_prev && !full_prev) exp_q.push_back({ins_prev, pc_prev});
        Fetch_Valid = fv;
        Instr_in    = ins;
        PC_plus4_in = pc;
        Flush       = fl;
        Dec_Ready   = rdy;
        fv_prev   = fv;
        fl_prev   = fl;
        ins_prev  = ins;
        pc_prev   = pc;
        full_prev = (exp_q.size() == DEPTH);
    endtask

    initial begin
        // Reset state.
        #1;
        chk("rst_count", 64'(Count), 64'h0);
        chk("rst_valid", 64'(Dec_Valid), 64'h0);
        chk("rst_pc_en", 64'(PC_EN), 64'h1);
        chk("rst_instr", 64'(Instr_out), 64'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge CLK); #1 RST = 1'b1;

        // Fill with decode stalled.
        step(1, 32'h20080001, 32'h4,  0, 0);
        step(1, 32'h20090002, 32'h8,  0, 0);
        step(1, 32'h200A0003, 32'hC,  0, 0);
        step(1, 32'h200B0004, 32'h10, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("full_count", 64'(Count), 64'h4);
        chk("full_pc_en", 64'(PC_EN), 64'h0);

        // Drain in order, then one empty cycle.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);

        // Steady streaming from Count = 1.
        step(1, 32'h00000100, 32'h100, 0, 0);
        for (int i = 0; i < 20; i++) step(1, $urandom, $urandom, 0, 1);
        step(1, $urandom, $urandom, 0, 0);
        step(1, $urandom, $urandom, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pre_flush_count", 64'(Count), 64'h3);

        // Flush beats simultaneous push and pop.
        step(1, 32'h0BADF00D, 32'h44, 1, 1);
        step(1, 32'h1000FFFF, 32'h80, 0, 0);
        chk("post_flush_count", 64'(Count), 64'h0);
        chk("post_flush_pc_en", 64'(PC_EN), 64'h1);
        step(0, 0, 0, 0, 0);
        chk("flush_target_head", 64'(Instr_out), 64'h1000FFFF);

        // Pops while empty are no-ops.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // Push refused while full even with a pop.
        for (int i = 0; i < 4; i++) step(1, 32'h30000000 + i, 32'h200 + 4 * i, 0, 0);
        step(1, 32'hDEADBEEF, 32'hBEEF, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("full_pop_count", 64'(Count), 64'h3);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Asynchronous reset between edges with Count = 2.
        chk("pre_reset_count", 64'(Count), 64'h2);
        Fetch_Valid = 1'b0; Dec_Ready = 1'b0; Flush = 1'b0;
        fv_prev = 1'b0; fl_prev = 1'b0; full_prev = 1'b0;
        #2 RST = 1'b0;
        #1;
        chk("arst_count", 64'(Count), 64'h0);
        chk("arst_valid", 64'(Dec_Valid), 64'h0);
        chk("arst_pc_en", 64'(PC_EN), 64'h1);
        chk("arst_instr", 64'(Instr_out), 64'h0);
        chk("arst_pc", 64'(PC_plus4_out), 64'h0);
        exp_q.delete();
        @(negedge CLK); #1 RST = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [WIDTH-1:0] ri;
            ri = $urandom;
            if (ri == 32'hDEADBEEF) ri = 32'h1;
            step($urandom_range(0, 3) != 0, ri, $urandom,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        chk("refused_pair_never_seen", 64'(seen_bad), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch buffer between the fetch stage (PC register plus instruction memory) and the decode stage of the pipelined MIPS core. It takes each fetched {instruction, PC+4} pair, queues up to DEPTH of them, and presents them in order to decode through a valid/ready handshake. When full, it deasserts the PC enable so fetch stalls. A taken branch flushes it, and it emits NOP bubbles (32'h0) while empty.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥ 2
- WIDTH, 32, width of the instruction and PC fields
- CLK  input  1  single clock; all state updates on rising edge
- RST  input  1  asynchronous, active-low reset
- Instr_in  input  WIDTH  instruction read from instruction memory at current PC
- PC_plus4_in  input  WIDTH  PC+4 of that instruction
- Fetch_Valid  input  1  fetch presents a valid pair this cycle
- Flush  input  1  taken branch (driven from the same signal as the PC mux select); discards all queued entries
- Dec_Ready  input  1  decode accepts the head entry this cycle
- PC_EN  output  1  enable for the PC register; equals !Full
- Dec_Valid  output  1  head entry valid; equals !Empty
- Instr_out  output  WIDTH  head instruction; 32'h0 when empty
- PC_plus4_out  output  WIDTH  head PC+4; 32'h0 when empty
- Count  output  log2(DEPTH)+1  number of occupied entries

## Operation
- Storage: circular array of DEPTH entries of {Instr, PC_plus4}, with write pointer wr_ptr and read pointer rd_ptr (log2(DEPTH) bits, natural wrap DEPTH-1 → 0) and a registered Count.
- Full = (Count == DEPTH). Empty = (Count == 0).
- push = Fetch_Valid && !Full. When Full, a push is refused even if a pop occurs in the same cycle; fetch is already stalled by PC_EN = 0.
- pop = Dec_Valid && Dec_Ready. Dec_Ready while empty has no effect.
- Per cycle, in priority order:
  - Flush = 1: Count ← 0, wr_ptr ← 0, rd_ptr ← 0. Any push and pop that cycle are discarded.
  - push && pop: write at wr_ptr, both pointers increment, Count unchanged.
  - push only: write, wr_ptr+1, Count+1.
  - pop only: rd_ptr+1, Count−1.
- Instr_out and PC_plus4_out come combinationally from entry[rd_ptr], masked to 0 when Empty. Decode therefore sees sll $0,$0,0 (NOP) as its bubble.
- Count never exceeds DEPTH and never underflows; a pop while empty and a push while full are both no-ops.

## Timing
- Reset (RST low, asynchronous): Count = 0, pointers = 0, so Dec_Valid = 0, PC_EN = 1, Instr_out = PC_plus4_out = 0. Storage contents are don't-care. Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (same cycle as the updated Count). There is no same-cycle bypass: with the queue empty, Fetch_Valid at cycle N gives Dec_Valid at cycle N+1.
- PC_EN and Dec_Valid are decoded only from registered Count, with no combinational path from inputs. PC_EN drops in the cycle after the DEPTH-th push, so the PC holds from that edge.
- Flush takes effect at the next edge. In the cycle after Flush, Dec_Valid = 0 and PC_EN = 1, so the branch-target fetch is accepted normally.
- Full with simultaneous pop: Count goes DEPTH → DEPTH−1 and PC_EN rises the next cycle. The pair presented during the full cycle is lost by design, because the PC was held and fetch re-presents it.

## Test plan
- Reset then fill: release RST and push 0x20080001/PC+4=0x4, 0x20090002/0x8, 0x200A0003/0xC, 0x200B0004/0x10 with Dec_Ready = 0 → Count reaches 4, PC_EN = 0 after the 4th edge, and Instr_out = 0x20080001 throughout.
- Drain in order: from full, hold Dec_Ready = 1 → outputs 0x20080001, 0x20090002, 0x200A0003, 0x200B0004 on consecutive cycles, then Dec_Valid = 0 with Instr_out = 0 and PC_EN = 1.
- Steady streaming: Fetch_Valid = Dec_Ready = 1 for 20 cycles starting from Count = 1 → Count stays 1, order is preserved, and pointers wrap past DEPTH−1 without loss.
- Flush priority: with Count = 3, assert Flush together with Fetch_Valid and Dec_Ready → next cycle Count = 0, Dec_Valid = 0, PC_EN = 1, and a subsequent push of 0x1000FFFF appears as the head.
- Boundaries: Dec_Ready = 1 while empty → Count stays 0. Fetch_Valid while full with Dec_Ready = 1 → Count goes 4 → 3 and the refused pair never appears on the outputs.
- Async reset mid-stream: drop RST between clock edges with Count = 2 → Count = 0, Dec_Valid = 0 and outputs 0 immediately, before the next edge.
